datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have one clock and synchronous, active-high reset; all register updates occur on the rising edge of clk.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 DA  input  3  destination register address.
REQ-005 AA  input  3  A-port register address.
REQ-006 BA  input  3  B-port register address; also the constant source when MB=1.
REQ-007 MB  input  1  B mux select: 0=R[BA], 1=constant.
REQ-008 FS  input  4  function-unit select.
REQ-009 MD  input  1  D mux select: 0=function result F, 1=Datain.
REQ-010 RW  input  1  register write enable.
REQ-011 Datain  input  16  external data for loads.
REQ-012 Dataout  output  16  bus B value after the MB mux.
REQ-013 da  output  16  R[DA] contents, combinational.
REQ-014 aa  output  16  R[AA] contents, combinational.
REQ-015 ba  output  16  R[BA] contents, combinational.

Function
REQ-016 SHALL contain 8x16-bit registers R0..R7; R0 is an ordinary writable register.
REQ-017 Bus A = R[AA]; bus B = MB ? {13'b0,BA} : R[BA]; all reads are combinational.
REQ-018 FS map, 16-bit modulo arithmetic: 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1 (A-B); 0110 A-1; 0111 A; 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>1 with 0 fill; 1110 B<<1 with 0 fill; 1111 16'h0000.
REQ-019 Write data = MD ? Datain : F; when RW=1, it SHALL be written to R[DA] at the clock edge, so latency is 1 cycle.
REQ-020 RW=0 SHALL leave all registers unchanged; F and Dataout still follow inputs combinationally.
REQ-021 Same-cycle read and write of one register SHALL read the old value; the new value is visible after the edge.
REQ-022 DA=AA=BA with RW=1 SHALL be legal; the result of the old operands is written.

Reset
REQ-023 With rst=1 at a clock edge, all registers SHALL clear to 16'h0000; rst has priority over RW.
REQ-024 After reset, da/aa/ba SHALL read 0 and Dataout = MB ? {13'b0,BA} : 0.

Configuration
REQ-025 Macro DATAPATH_STATUS_EN, when defined, SHALL add combinational outputs V, C, N, Z (1 bit each).
- C = adder carry-out for FS 0000-0111, else 0.
- V = signed overflow for FS 0000-0111, else 0.
- N = F[15].
- Z = (F==0).
REQ-026 Without DATAPATH_STATUS_EN, these ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Shared package datapath_pkg SHALL hold:
- data width 16, register count 8, address width 3;
- FS opcode constants (FS_TSA, FS_INC, FS_ADD, ..., FS_SHL).
REQ-028 The function unit SHALL be a sub-module, function_unit (A, B, FS -> F, plus flags when enabled); the register file stays inline.

Verification
REQ-029 rst=1 for one edge after arbitrary writes -> all of da/aa/ba read 0 for every address.
REQ-030 Load sequence, then subtract:
- MD=1, RW=1, DA=1, Datain=5; then DA=2, Datain=3 -> R1=5, R2=3.
- Then FS=0101, AA=1, BA=2, DA=3, MD=0 -> R3=2 after the edge.
REQ-031 Constant add: MB=1, BA=4, AA=1, FS=0010, DA=4 -> Dataout=4, R4=9.
REQ-032 Shift: FS=1110, BA=2, DA=5 -> R5=6; FS=1101, BA=1, DA=6 -> R6=2.
REQ-033 RW=0 with FS=0001, DA=1 -> R1 stays 5 while aa/Dataout follow AA/BA.
REQ-034 With DATAPATH_STATUS_EN:
- A=16'h7FFF, FS=0001 -> F=16'h8000, V=1, N=1, Z=0, C=0.
- A=16'hFFFF, FS=0001 -> F=0, Z=1, C=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared widths and function-select opcodes for the datapath and its function unit.
package datapath_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_N  = 8;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned FS_W   = 4;

   localparam logic [FS_W-1:0] FS_TSA  = 4'h0;  // A
   localparam logic [FS_W-1:0] FS_INC  = 4'h1;  // A+1
   localparam logic [FS_W-1:0] FS_ADD  = 4'h2;  // A+B
   localparam logic [FS_W-1:0] FS_ADDC = 4'h3;  // A+B+1
   localparam logic [FS_W-1:0] FS_ADDN = 4'h4;  // A+~B
   localparam logic [FS_W-1:0] FS_SUB  = 4'h5;  // A+~B+1
   localparam logic [FS_W-1:0] FS_DEC  = 4'h6;  // A-1
   localparam logic [FS_W-1:0] FS_TSA2 = 4'h7;  // A
   localparam logic [FS_W-1:0] FS_AND  = 4'h8;
   localparam logic [FS_W-1:0] FS_OR   = 4'h9;
   localparam logic [FS_W-1:0] FS_XOR  = 4'hA;
   localparam logic [FS_W-1:0] FS_NOT  = 4'hB;
   localparam logic [FS_W-1:0] FS_TSB  = 4'hC;
   localparam logic [FS_W-1:0] FS_SHR  = 4'hD;
   localparam logic [FS_W-1:0] FS_SHL  = 4'hE;
   localparam logic [FS_W-1:0] FS_ZERO = 4'hF;

   // Opcodes 0000-0111 all go through the adder.
   function automatic logic is_arith(input logic [FS_W-1:0] fs);
      return ~fs[FS_W-1];
   endfunction

endpackage

// File: rtl/datapath_function_unit.sv
// Combinational function unit: adder/logic/shift selected by FS.
// Status flags V, C, N, Z exist only when DATAPATH_STATUS_EN is defined.
module function_unit
   import datapath_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [FS_W-1:0]   fs,
   output logic [DATA_W-1:0] f
`ifdef DATAPATH_STATUS_EN
   ,
   output logic              v,
   output logic              c,
   output logic              n,
   output logic              z
`endif
);

`ifdef DATAPATH_STATUS_EN
   localparam int unsigned SUM_W = DATA_W + 1;
`else
   localparam int unsigned SUM_W = DATA_W;
`endif

   logic [DATA_W-1:0] b_op;
   logic              cin;
   logic [SUM_W-1:0]  sum;

   // Adder operand and carry-in per arithmetic opcode.
   always_comb begin
      b_op = '0;
      cin  = 1'b0;
      case (fs[2:0])
         3'd1:    cin = 1'b1;
         3'd2:    b_op = b;
         3'd3:    begin b_op = b;  cin = 1'b1; end
         3'd4:    b_op = ~b;
         3'd5:    begin b_op = ~b; cin = 1'b1; end
         3'd6:    b_op = '1;
         default: ;
      endcase
   end

   assign sum = SUM_W'(a) + SUM_W'(b_op) + SUM_W'(cin);

   always_comb begin
      f = '0;
      case (fs)
         FS_AND:  f = a & b;
         FS_OR:   f = a | b;
         FS_XOR:  f = a ^ b;
         FS_NOT:  f = ~a;
         FS_TSB:  f = b;
         FS_SHR:  f = b >> 1;
         FS_SHL:  f = b << 1;
         FS_ZERO: f = '0;
         default: f = sum[DATA_W-1:0];
      endcase
   end

`ifdef DATAPATH_STATUS_EN
   assign c = is_arith(fs) & sum[DATA_W];
   assign v = is_arith(fs) & (a[DATA_W-1] == b_op[DATA_W-1])
                           & (sum[DATA_W-1] != a[DATA_W-1]);
   assign n = f[DATA_W-1];
   assign z = (f == '0);
`endif

endmodule

// File: rtl/datapath.sv
// 8x16 register file with A/B read buses, B constant mux, function unit and load mux.
// Define DATAPATH_STATUS_EN to add the V, C, N, Z status outputs.
module datapath
   import datapath_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] DA,
   input  logic [ADDR_W-1:0] AA,
   input  logic [ADDR_W-1:0] BA,
   input  logic              MB,
   input  logic [FS_W-1:0]   FS,
   input  logic              MD,
   input  logic              RW,
   input  logic [DATA_W-1:0] Datain,
   output logic [DATA_W-1:0] Dataout,
   output logic [DATA_W-1:0] da,
   output logic [DATA_W-1:0] aa,
   output logic [DATA_W-1:0] ba
`ifdef DATAPATH_STATUS_EN
   ,
   output logic              V,
   output logic              C,
   output logic              N,
   output logic              Z
`endif
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic [DATA_W-1:0] bus_a;
   logic [DATA_W-1:0] bus_b;
   logic [DATA_W-1:0] f;
   logic [DATA_W-1:0] wr_data;

   assign da      = regs_q[DA];
   assign aa      = regs_q[AA];
   assign ba      = regs_q[BA];
   assign bus_a   = regs_q[AA];
   assign bus_b   = MB ? DATA_W'(BA) : regs_q[BA];
   assign Dataout = bus_b;
   assign wr_data = MD ? Datain : f;

   function_unit u_fu (
      .a  (bus_a),
      .b  (bus_b),
      .fs (FS),
      .f  (f)
`ifdef DATAPATH_STATUS_EN
      ,
      .v  (V),
      .c  (C),
      .n  (N),
      .z  (Z)
`endif
   );

   // Reads see the pre-edge contents, so same-cycle read/write returns the old value.
   always_comb begin
      regs_d = regs_q;
      if (RW) begin
         regs_d[DA] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_N); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed vector table, reset sweeps and
// randomized traffic against an arithmetic reference model.
module tb_datapath;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  DA, AA, BA;
   logic        MB, MD, RW;
   logic [3:0]  FS;
   logic [15:0] Datain;
   logic [15:0] Dataout, da, aa, ba;
`ifdef DATAPATH_STATUS_EN
   logic        V, C, N, Z;
`endif

   int checks = 0;
   int errors = 0;
   logic [15:0] model [8];

   always #5 clk = ~clk;

   datapath dut (
      .clk     (clk),
      .rst     (rst),
      .DA      (DA),
      .AA      (AA),
      .BA      (BA),
      .MB      (MB),
      .FS      (FS),
      .MD      (MD),
      .RW      (RW),
      .Datain  (Datain),
      .Dataout (Dataout),
      .da      (da),
      .aa      (aa),
      .ba      (ba)
`ifdef DATAPATH_STATUS_EN
      ,
      .V       (V),
      .C       (C),
      .N       (N),
      .Z       (Z)
`endif
   );

   typedef struct {
      logic        rst;
      logic [2:0]  da, aa, ba;
      logic        mb;
      logic [3:0]  fs;
      logic        md, rw;
      logic [15:0] din;
      logic [15:0] exp_dout;
      logic [15:0] exp_aa;
      logic [2:0]  chk;
      logic [15:0] exp_reg;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference function result from plain integer arithmetic, reduced mod 2^16.
   function automatic logic [15:0] ref_f(input logic [15:0] a16, input logic [15:0] b16,
                                         input logic [3:0] fs);
      int a = int'(a16);
      int b = int'(b16);
      int r;
      case (fs)
         4'd1:    r = a + 1;
         4'd2:    r = a + b;
         4'd3:    r = a + b + 1;
         4'd4:    r = a + (65535 - b);
         4'd5:    r = a - b;
         4'd6:    r = a - 1;
         4'd8:    r = a & b;
         4'd9:    r = a | b;
         4'd10:   r = a ^ b;
         4'd11:   r = 65535 - a;
         4'd12:   r = b;
         4'd13:   r = b / 2;
         4'd14:   r = b * 2;
         4'd15:   r = 0;
         default: r = a;
      endcase
      return 16'(r);
   endfunction

   // {V,C,N,Z}: carry from the unsigned sum, overflow from the signed sum.
   function automatic logic [3:0] ref_flags(input logic [15:0] a16, input logic [15:0] b16,
                                            input logic [3:0] fs, input logic [15:0] f16);
      int a = int'(a16);
      int b = int'(b16);
      int op = 0;
      int cin = 0;
      int sa, so, s;
      logic v = 1'b0;
      logic c = 1'b0;
      if (fs < 4'd8) begin
         case (fs)
            4'd1:    cin = 1;
            4'd2:    op = b;
            4'd3:    begin op = b; cin = 1; end
            4'd4:    op = 65535 - b;
            4'd5:    begin op = 65535 - b; cin = 1; end
            4'd6:    op = 65535;
            default: ;
         endcase
         c  = (a + op + cin) > 65535;
         sa = (a > 32767) ? a - 65536 : a;
         so = (op > 32767) ? op - 65536 : op;
         s  = sa + so + cin;
         v  = (s > 32767) || (s < -32768);
      end
      return {v, c, f16[15], f16 == 16'h0000};
   endfunction

   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 8; i++) begin
         DA = 3'(i); AA = 3'(i); BA = 3'(i); MB = 1'b0; RW = 1'b0; rst = 1'b0;
         #1;
         chk({tag, "_da"}, da, 16'h0000);
         chk({tag, "_aa"}, aa, 16'h0000);
         chk({tag, "_ba"}, ba, 16'h0000);
         MB = 1'b1;
         #1;
         chk({tag, "_const"}, Dataout, 16'(i));
      end
   endtask

   initial begin
      vecs[0] = '{1'b0, 3'd1, 3'd0, 3'd0, 1'b0, 4'd0,  1'b1, 1'b1, 16'd5,     16'd0,     16'd0,     3'd1, 16'd5};
      vecs[1] = '{1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 4'd0,  1'b1, 1'b1, 16'd3,     16'd0,     16'd5,     3'd2, 16'd3};
      vecs[2] = '{1'b0, 3'd3, 3'd1, 3'd2, 1'b0, 4'd5,  1'b0, 1'b1, 16'd0,     16'd3,     16'd5,     3'd3, 16'd2};
      vecs[3] = '{1'b0, 3'd4, 3'd1, 3'd4, 1'b1, 4'd2,  1'b0, 1'b1, 16'd0,     16'd4,     16'd5,     3'd4, 16'd9};
      vecs[4] = '{1'b0, 3'd5, 3'd0, 3'd2, 1'b0, 4'd14, 1'b0, 1'b1, 16'd0,     16'd3,     16'd0,     3'd5, 16'd6};
      vecs[5] = '{1'b0, 3'd6, 3'd0, 3'd1, 1'b0, 4'd13, 1'b0, 1'b1, 16'd0,     16'd5,     16'd0,     3'd6, 16'd2};
      vecs[6] = '{1'b0, 3'd1, 3'd1, 3'd3, 1'b0, 4'd1,  1'b0, 1'b0, 16'd0,     16'd2,     16'd5,     3'd1, 16'd5};
      vecs[7] = '{1'b0, 3'd7, 3'd0, 3'd0, 1'b0, 4'd0,  1'b1, 1'b1, 16'h1234,  16'd0,     16'd0,     3'd7, 16'h1234};
      vecs[8] = '{1'b0, 3'd7, 3'd7, 3'd7, 1'b0, 4'd2,  1'b0, 1'b1, 16'd0,     16'h1234,  16'h1234,  3'd7, 16'h2468};
      vecs[9] = '{1'b1, 3'd1, 3'd1, 3'd5, 1'b1, 4'd0,  1'b1, 1'b1, 16'hFFFF,  16'd5,     16'd5,     3'd1, 16'd0};

      rst = 1'b1; DA = '0; AA = '0; BA = '0; MB = 1'b0; FS = '0; MD = 1'b0; RW = 1'b1;
      Datain = 16'hDEAD;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; DA = vecs[i].da; AA = vecs[i].aa; BA = vecs[i].ba;
         MB = vecs[i].mb; FS = vecs[i].fs; MD = vecs[i].md; RW = vecs[i].rw;
         Datain = vecs[i].din;
         #1;
         chk($sformatf("vec%0d_dout", i), Dataout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_aa_old", i), aa, vecs[i].exp_aa);
         @(posedge clk);
         #1;
         rst = 1'b0; RW = 1'b0; AA = vecs[i].chk;
         #1;
         chk($sformatf("vec%0d_reg", i), aa, vecs[i].exp_reg);
      end
      check_all_zero("vec_rst");

      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      for (int n = 0; n < 400; n++) begin
         logic [15:0] exp_b, exp_f;
         @(negedge clk);
         rst = ($urandom_range(31) == 0);
         DA = 3'($urandom); AA = 3'($urandom); BA = 3'($urandom);
         MB = 1'($urandom); FS = 4'($urandom); MD = 1'($urandom);
         RW = ($urandom_range(3) != 0); Datain = 16'($urandom);
         #1;
         exp_b = MB ? 16'(BA) : model[BA];
         exp_f = ref_f(model[AA], exp_b, FS);
         chk("rand_dout", Dataout, exp_b);
         chk("rand_da", da, model[DA]);
         chk("rand_aa", aa, model[AA]);
         chk("rand_ba", ba, model[BA]);
`ifdef DATAPATH_STATUS_EN
         chk("rand_flags", {12'h000, V, C, N, Z}, {12'h000, ref_flags(model[AA], exp_b, FS, exp_f)});
`endif
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
         end else if (RW) begin
            model[DA] = MD ? Datain : exp_f;
         end
         #1;
      end

      // Reset after arbitrary random writes: a single edge clears everything.
      @(negedge clk);
      rst = 1'b1; RW = 1'b1; MD = 1'b1; Datain = 16'hBEEF;
      @(posedge clk);
      #1;
      check_all_zero("rand_rst");

`ifdef DATAPATH_STATUS_EN
      @(negedge clk);
      rst = 1'b0; MB = 1'b0; RW = 1'b1; MD = 1'b1; DA = 3'd1; Datain = 16'h7FFF;
      @(negedge clk);
      AA = 3'd1; FS = 4'd1; MD = 1'b0; DA = 3'd2;
      #1;
      chk("flags_7fff_inc", {12'h000, V, C, N, Z}, 16'h000A);
      @(posedge clk);
      #1;
      RW = 1'b0; AA = 3'd2;
      #1;
      chk("f_7fff_inc", aa, 16'h8000);
      @(negedge clk);
      RW = 1'b1; MD = 1'b1; DA = 3'd1; Datain = 16'hFFFF;
      @(negedge clk);
      AA = 3'd1; FS = 4'd1; MD = 1'b0; DA = 3'd2;
      #1;
      chk("flags_ffff_inc", {12'h000, V, C, N, Z}, 16'h0005);
      @(posedge clk);
      #1;
      RW = 1'b0; AA = 3'd2;
      #1;
      chk("f_ffff_inc", aa, 16'h0000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
